// File: rtl/ppu_vga_pkg.sv
// ============================================================================
//  ppu_vga_pkg
//  VGA 640x480@60 timing, NES colour types and the 64-entry NES RGB palette.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ppu_vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int PPU_W   = 256;
  localparam int PPU_H   = 240;

  typedef logic [5:0]  nes_idx_t;
  typedef logic [23:0] rgb24_t;

  localparam rgb24_t NES_PALETTE [64] = '{
    24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
    24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
    24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
    24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
    24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
    24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
  };

endpackage

`default_nettype wire

// File: rtl/ppu_vga_scanconv_palette.sv
// ============================================================================
//  nes_palette_rom
//  Registered 64x24 NES colour-index to RGB lookup, advanced on the pixel strobe.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module nes_palette_rom
  import ppu_vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [5:0]  idx,
  output logic [23:0] rgb
);

  logic [23:0] r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else if (en) begin
      r_rgb <= NES_PALETTE[idx];
    end
  end

  assign rgb = r_rgb;

endmodule

`default_nettype wire

// File: rtl/ppu_vga_scanconv.sv
// ============================================================================
//  ppu_vga_scanconv
//  Line-doubling PPU-to-VGA scan converter with palette lookup.
//  Optional macro SCANLINE_EFFECT_EN halves brightness on odd VGA rows.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ppu_vga_scanconv
  import ppu_vga_pkg::*;
#(
  parameter int         H_BORDER      = 64,
  parameter logic [5:0] BORDER_COLOUR = 6'h0F
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       pix_valid,
  input  logic [5:0] pix_data,
  input  logic [7:0] pix_x,
  input  logic [7:0] pix_y,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [8:0] vga_line
);

  localparam logic [9:0] c_h_last   = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last   = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_VIS);
  localparam logic [9:0] c_v_vis    = 10'(V_VIS);
  localparam logic [9:0] c_hs_start = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] c_img_lo   = 10'(H_BORDER);
  localparam logic [9:0] c_img_hi   = 10'(H_BORDER + 2 * PPU_W);
  localparam logic [7:0] c_ppu_h    = 8'(PPU_H);
  localparam logic [7:0] c_last_x   = 8'(PPU_W - 1);

  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic        w_vis;
  logic        w_hs_n;
  logic        w_vs_n;
  logic [7:0]  w_src_line;
  logic        w_rd_bank;
  logic        w_in_image;
  logic [9:0]  w_hoff;
  logic [7:0]  w_rd_addr;
  logic        w_line_ok;
  logic        w_wr;

  logic [5:0]  r_lbuf [2][256];
  logic [1:0]  r_valid;
  logic [7:0]  r_line [2];

  logic [5:0]  r_s1_idx;
  logic        r_s1_vis;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s2_vis;
  logic        r_s2_hs;
  logic        r_s2_vs;
  logic [23:0] w_pal_rgb;
  logic [23:0] w_pix;
  logic [23:0] w_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (pix_en) begin
      if (r_hcnt == c_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == c_v_last) ? '0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  assign w_vis      = (r_hcnt < c_h_vis) && (r_vcnt < c_v_vis);
  assign w_hs_n     = !((r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end));
  assign w_vs_n     = !((r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end));
  assign w_src_line = r_vcnt[8:1];
  assign w_rd_bank  = w_src_line[0];
  assign w_in_image = w_vis && (r_hcnt >= c_img_lo) && (r_hcnt < c_img_hi);
  assign w_hoff     = r_hcnt - c_img_lo;
  assign w_rd_addr  = 8'(w_hoff >> 1);
  // A bank only shows if it holds a complete copy of exactly the line being scanned.
  assign w_line_ok  = r_valid[w_rd_bank] && (r_line[w_rd_bank] == w_src_line);
  assign w_wr       = pix_valid && (pix_y < c_ppu_h);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_lbuf[pix_y[0]][pix_x] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_line[0] <= '0;
      r_line[1] <= '0;
    end else if (w_wr && (pix_x == c_last_x)) begin
      r_valid[pix_y[0]] <= 1'b1;
      r_line[pix_y[0]]  <= pix_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_idx <= '0;
      r_s1_vis <= 1'b0;
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
      r_s2_vis <= 1'b0;
      r_s2_hs  <= 1'b1;
      r_s2_vs  <= 1'b1;
    end else if (pix_en) begin
      r_s1_idx <= (w_in_image && w_line_ok) ? r_lbuf[w_rd_bank][w_rd_addr] : BORDER_COLOUR;
      r_s1_vis <= w_vis;
      r_s1_hs  <= w_hs_n;
      r_s1_vs  <= w_vs_n;
      r_s2_vis <= r_s1_vis;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
    end
  end

  nes_palette_rom u_palette (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .idx   (r_s1_idx),
    .rgb   (w_pal_rgb)
  );

  assign w_pix = r_s2_vis ? w_pal_rgb : '0;

`ifdef SCANLINE_EFFECT_EN
  logic r_s1_dim;
  logic r_s2_dim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_dim <= 1'b0;
      r_s2_dim <= 1'b0;
    end else if (pix_en) begin
      r_s1_dim <= r_vcnt[0];
      r_s2_dim <= r_s1_dim;
    end
  end

  assign w_out = r_s2_dim ? {1'b0, w_pix[23:17], 1'b0, w_pix[15:9], 1'b0, w_pix[7:1]} : w_pix;
`else
  assign w_out = w_pix;
`endif

  assign vga_r       = w_out[23:16];
  assign vga_g       = w_out[15:8];
  assign vga_b       = w_out[7:0];
  assign vga_hs      = r_s2_hs;
  assign vga_vs      = r_s2_vs;
  assign vga_blank_n = r_s2_vis;
  // Rows 512-524 alias onto 0-12 in this 9-bit view; they are all vertical blanking.
  assign vga_line    = r_vcnt[8:0];

endmodule

`default_nettype wire

// File: tb/tb_ppu_vga_scanconv.sv
// ============================================================================
//  tb_ppu_vga_scanconv
//  Randomised bench for ppu_vga_scanconv against a position-based frame model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ppu_vga_scanconv;
  import ppu_vga_pkg::*;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank_n;
  } px_t;

  localparam px_t PX_RESET = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
`ifdef SCANLINE_EFFECT_EN
  localparam logic [23:0] WHITE_ODD = 24'h7F7F7F;
  localparam logic [23:0] RED_ODD   = 24'h5A1810;
`else
  localparam logic [23:0] WHITE_ODD = 24'hFFFEFF;
  localparam logic [23:0] RED_ODD   = 24'hB53120;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       pix_valid;
  logic [5:0] pix_data;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n;
  logic [8:0] vga_line;

  int tests = 0;
  int fails = 0;
  int sn    = 0;

  always #5 clk = ~clk;

  ppu_vga_scanconv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_line    (vga_line)
  );

  // Reference: screen position n -> expected pixel from the PPU lines stored so far.
  int         m_n;
  logic [5:0] m_mem [2][256];
  logic       m_valid [2];
  int         m_line [2];
  px_t        m_p1, m_p2;

  function automatic px_t model_pixel(input int n);
    int  h, v, src, b, idx;
    px_t p;
    h = n % 800;
    v = (n / 800) % 525;
    p.hs      = !(h >= 656 && h < 752);
    p.vs      = !(v >= 490 && v < 492);
    p.blank_n = (h < 640) && (v < 480);
    p.rgb     = 24'h0;
    if (p.blank_n) begin
      src = v / 2;
      b   = src % 2;
      idx = 'h0F;
      if (h >= 64 && h < 576 && m_valid[b] && m_line[b] == src) idx = int'(m_mem[b][(h - 64) / 2]);
      p.rgb = NES_PALETTE[idx];
`ifdef SCANLINE_EFFECT_EN
      if (v % 2 == 1) p.rgb = {p.rgb[23:16] >> 1, p.rgb[15:8] >> 1, p.rgb[7:0] >> 1};
`endif
    end
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n        <= 0;
      m_valid[0] <= 1'b0;
      m_valid[1] <= 1'b0;
      m_line[0]  <= 0;
      m_line[1]  <= 0;
      m_p1       <= PX_RESET;
      m_p2       <= PX_RESET;
    end else begin
      if (pix_en) begin
        m_p1 <= model_pixel(m_n);
        m_p2 <= m_p1;
        m_n  <= m_n + 1;
      end
      if (pix_valid && pix_y < 8'd240) begin
        m_mem[pix_y[0]][pix_x] <= pix_data;
        if (pix_x == 8'd255) begin
          m_valid[pix_y[0]] <= 1'b1;
          m_line[pix_y[0]]  <= int'(pix_y);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] exp_line;
    exp_line = 9'((m_n / 800) % 525);
    tests = tests + 3;
    if ({vga_r, vga_g, vga_b} !== m_p2.rgb) begin
      fails = fails + 1;
      $display("FAIL rgb n=%0d: got %h expected %h", m_n, {vga_r, vga_g, vga_b}, m_p2.rgb);
    end
    if ({vga_hs, vga_vs, vga_blank_n} !== {m_p2.hs, m_p2.vs, m_p2.blank_n}) begin
      fails = fails + 1;
      $display("FAIL sync n=%0d: got hs/vs/blank_n=%b%b%b expected %b%b%b", m_n,
               vga_hs, vga_vs, vga_blank_n, m_p2.hs, m_p2.vs, m_p2.blank_n);
    end
    if (vga_line !== exp_line) begin
      fails = fails + 1;
      $display("FAIL vga_line n=%0d: got %0d expected %0d", m_n, vga_line, exp_line);
    end
  end

  task automatic tick(input logic en, input logic v, input logic [7:0] x,
                      input logic [7:0] y, input logic [5:0] d);
    pix_en    = en;
    pix_valid = v;
    pix_x     = x;
    pix_y     = y;
    pix_data  = d;
    if (en && rst_n) sn = sn + 1;
    @(negedge clk);
  endtask

  function automatic logic rnd_en(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic idle_to(input int target, input int pct);
    while (sn < target) tick(rnd_en(pct), 1'b0, 8'd0, 8'd0, 6'd0);
  endtask

  // mode 0: constant 0x30, mode 1: X[5:0], mode 2: random
  task automatic write_line(input int y, input int mode, input logic v, input int pct);
    logic [5:0] d;
    for (int x = 0; x < 256; x++) begin
      while ($urandom_range(0, 3) == 0) tick(rnd_en(pct), 1'b0, 8'd0, 8'd0, 6'd0);
      d = (mode == 0) ? 6'h30 : (mode == 1) ? 6'(x) : 6'($urandom_range(0, 63));
      tick(rnd_en(pct), v, 8'(x), 8'(y), d);
    end
  endtask

  task automatic check_px(input string name, input logic [23:0] exp_rgb, input logic exp_blank);
    tests = tests + 1;
    if ({vga_r, vga_g, vga_b} !== exp_rgb || vga_blank_n !== exp_blank) begin
      fails = fails + 1;
      $display("FAIL %s: got rgb=%h blank_n=%b expected rgb=%h blank_n=%b",
               name, {vga_r, vga_g, vga_b}, vga_blank_n, exp_rgb, exp_blank);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_px(name, 24'h0, 1'b0);
    check_bit({name, "_hs"}, vga_hs, 1'b1);
    check_bit({name, "_vs"}, vga_vs, 1'b1);
  endtask

  task automatic check_line(input string name, input int exp);
    tests = tests + 1;
    if (int'(vga_line) != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", name, vga_line, exp);
    end
  endtask

  initial begin
    int src, r;
    rst_n = 1'b0;
    pix_en = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_x = '0; pix_y = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Line 0 all white, written while the scan is paused.
    write_line(0, 0, 1'b1, 0);
    check_line("paused_line", 0);
    idle_to(65, 100);   check_px("row0_col63_border", 24'h000000, 1'b1);
    idle_to(66, 100);   check_px("row0_col64_first", 24'hFFFEFF, 1'b1);
    idle_to(320, 100);  check_px("row0_col318", 24'hFFFEFF, 1'b1);
    idle_to(577, 100);  check_px("row0_col575_last", 24'hFFFEFF, 1'b1);
    idle_to(578, 100);  check_px("row0_col576_border", 24'h000000, 1'b1);
    idle_to(642, 100);  check_px("row0_col640_blank", 24'h000000, 1'b0);
    idle_to(657, 100);  check_bit("hs_before", vga_hs, 1'b1);
    idle_to(658, 100);  check_bit("hs_start", vga_hs, 1'b0);
    idle_to(753, 100);  check_bit("hs_last", vga_hs, 1'b0);
    idle_to(754, 100);  check_bit("hs_end", vga_hs, 1'b1);
    idle_to(902, 100);  check_px("row1_col100", WHITE_ODD, 1'b1);

    // Line 2 ramps X[5:0]; line 3 offered with PIX_VALID low only.
    idle_to(1600, 75);
    write_line(2, 1, 1'b1, 75);
    write_line(3, 2, 1'b0, 75);
    idle_to(4 * 800 + 108 + 2, 75); check_px("row4_col108_idx16", 24'hB53120, 1'b1);
    idle_to(4 * 800 + 109 + 2, 75); check_px("row4_col109_idx16", 24'hB53120, 1'b1);
    idle_to(5 * 800 + 108 + 2, 75); check_px("row5_col108_idx16", RED_ODD, 1'b1);
    idle_to(6 * 800 + 200 + 2, 75); check_px("row6_line3_unwritten", 24'h000000, 1'b1);

    // Random traffic: upcoming lines, rewrites of the line on screen, off-screen Y.
    while (sn < 40 * 800) begin
      src = (sn / 800) / 2;
      r   = $urandom_range(0, 9);
      if (r < 6) begin
        write_line(src + 1, 2, 1'b1, 75);
      end else if (r < 8) begin
        repeat (20) tick(rnd_en(75), 1'b1, 8'($urandom_range(0, 255)),
                         8'($urandom_range(240, 255)), 6'($urandom_range(0, 63)));
      end else begin
        write_line(src, 2, 1'b1, 75);
      end
      repeat ($urandom_range(0, 300)) tick(rnd_en(75), 1'b0, 8'd0, 8'd0, 6'd0);
    end

    // Asynchronous reset mid-line.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    pix_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sn = 0;
    @(negedge clk);
    check_line("line_after_reset", 0);
    idle_to(700, 80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
